// File: rtl/prime_pkg.sv
// Shared types and constants for the next-prime search engine.
package prime_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      DIV   = 3'd2,
      NEXT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int WIDTH_DEFAULT = 11;
   localparam int FIRST_DIVISOR = 3;

endpackage

// File: rtl/trial_divider.sv
// Restoring divider producing only the remainder; one quotient bit per cycle,
// the first bit is resolved on the go edge so the result lands in WIDTH cycles.
module trial_divider #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             done_q;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                             input logic             b,
                                             input logic [WIDTH-1:0] d);
      logic [WIDTH:0] t;
      t = {r, b};
      if (t >= {1'b0, d}) t = t - {1'b0, d};
      return t[WIDTH-1:0];
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q   <= '0;
         shift_q <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (go) begin
            rem_q   <= step('0, dividend[WIDTH-1], divisor);
            shift_q <= dividend << 1;
            dvs_q   <= divisor;
            cnt_q   <= CW'(WIDTH - 1);
            done_q  <= (WIDTH == 1);
         end else if (cnt_q != '0) begin
            rem_q   <= step(rem_q, shift_q[WIDTH-1], dvs_q);
            shift_q <= shift_q << 1;
            cnt_q   <= cnt_q - CW'(1);
            done_q  <= (cnt_q == CW'(1));
         end
      end
   end

   assign done      = done_q;
   assign remainder = rem_q;

endmodule

// File: rtl/prime_generator.sv
// Next-prime search: smallest prime >= seed by odd trial division up to sqrt.
//   state | meaning
//   IDLE  | waiting for start
//   CHECK | divisor^2 > candidate ? accept : launch trial division
//   DIV   | divider running for WIDTH cycles
//   NEXT  | candidate composite, step to next odd value
//   DONE  | result presented, waiting for ready
module prime_generator
   import prime_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   output logic             busy,
   output logic [WIDTH-1:0] prime,
   output logic             valid,
   input  logic             ready,
   output logic             overflow
);

   state_t           state, state_next;
   logic [WIDTH-1:0] candidate, candidate_next;
   logic [WIDTH-1:0] divisor, divisor_next;
   logic [WIDTH-1:0] prime_q, prime_next;
   logic             overflow_q, overflow_next;
   logic             go;
   logic             div_done;
   logic [WIDTH-1:0] remainder;
   logic [2*WIDTH-1:0] div_sq;
   logic [WIDTH:0]     cand_plus2;

   assign div_sq     = {{WIDTH{1'b0}}, divisor} * {{WIDTH{1'b0}}, divisor};
   assign cand_plus2 = {1'b0, candidate} + (WIDTH+1)'(2);
   assign go         = (state == CHECK) && (div_sq <= {{WIDTH{1'b0}}, candidate});

   trial_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .dividend  (candidate),
      .divisor   (divisor),
      .done      (div_done),
      .remainder (remainder)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         candidate  <= '0;
         divisor    <= '0;
         prime_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_next;
         candidate  <= candidate_next;
         divisor    <= divisor_next;
         prime_q    <= prime_next;
         overflow_q <= overflow_next;
      end
   end

   always_comb begin
      state_next     = state;
      candidate_next = candidate;
      divisor_next   = divisor;
      prime_next     = prime_q;
      overflow_next  = overflow_q;
      case (state)
         IDLE: begin
            if (start) begin
               overflow_next = 1'b0;
               if (seed <= WIDTH'(2)) begin
                  prime_next = WIDTH'(2);
                  state_next = DONE;
               end else begin
                  // even seeds start one above; odd seeds start on themselves
                  candidate_next = seed[0] ? seed : seed + WIDTH'(1);
                  divisor_next   = WIDTH'(FIRST_DIVISOR);
                  state_next     = CHECK;
               end
            end
         end
         CHECK: begin
            if (go) begin
               state_next = DIV;
            end else begin
               prime_next = candidate;
               state_next = DONE;
            end
         end
         DIV: begin
            if (div_done) begin
               if (remainder == '0) begin
                  state_next = NEXT;
               end else begin
                  divisor_next = divisor + WIDTH'(2);
                  state_next   = CHECK;
               end
            end
         end
         NEXT: begin
            if (cand_plus2[WIDTH]) begin
               prime_next    = '0;
               overflow_next = 1'b1;
               state_next    = DONE;
            end else begin
               candidate_next = cand_plus2[WIDTH-1:0];
               divisor_next   = WIDTH'(FIRST_DIVISOR);
               state_next     = CHECK;
            end
         end
         DONE: begin
            if (ready) begin
               overflow_next = 1'b0;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign valid    = (state == DONE);
   assign prime    = prime_q;
   assign overflow = overflow_q;

endmodule
